// File: rtl/fetch_unit_buffered.sv
// Buffered instruction-fetch stage.
// Issues sequential PC reads to a 1-cycle-latency instruction SRAM, queues the
// returned words in a PC-tagged FIFO and hands them to decode over valid/ready.
// A redirect empties the queue, kills the outstanding response and refetches
// from the (word-aligned) target in the same cycle.
module fetch_unit_buffered #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = {WIDTH{1'b0}},
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            imem_en,
  output logic [WIDTH-1:0]                imem_addr,
  input  logic [WIDTH-1:0]                imem_rdata,
  input  logic                            redirect_valid,
  input  logic [WIDTH-1:0]                redirect_target,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_instr,
  output logic [WIDTH-1:0]                out_pc,
  output logic                            out_pred_taken,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // Fetch-side state
  logic [WIDTH-1:0] fetch_pc_r;
  logic             inflight_r;
  logic [WIDTH-1:0] inflight_pc_r;

  // Instruction buffer
  logic [WIDTH-1:0] instr_mem_r [FIFO_DEPTH];
  logic [WIDTH-1:0] pc_mem_r    [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [LW-1:0]    count_r;

  // Combinational control
  logic [WIDTH-1:0] addr_s;
  logic [LW:0]      occ_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  logic             valid_s;
  logic [LW-1:0]    count_next_s;

  // Request address, issue decision and FIFO push/pop qualifiers
  always_comb begin
    addr_s  = fetch_pc_r;
    issue_s = 1'b0;
    if (redirect_valid) begin
      addr_s = {redirect_target[WIDTH-1:2], 2'b00};
    end else begin
      addr_s = fetch_pc_r;
    end
    // Space is counted conservatively: a pop this cycle does not free a slot.
    occ_s = {1'b0, count_r} + {{LW{1'b0}}, inflight_r};
    if (rst) begin
      issue_s = 1'b0;
    end else if (redirect_valid) begin
      // The queue is being flushed, so there is always room for the target.
      issue_s = 1'b1;
    end else begin
      issue_s = (occ_s < (LW + 1)'(FIFO_DEPTH));
    end
    valid_s = (count_r != {LW{1'b0}});
    pop_s   = valid_s && out_ready;
    // A response landing during a redirect belongs to the abandoned path.
    push_s  = inflight_r && !redirect_valid && !rst;
  end

  // Next buffer occupancy
  always_comb begin
    count_next_s = count_r;
    if (redirect_valid) begin
      count_next_s = {LW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + LW'(1);
        2'b01:   count_next_s = count_r - LW'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Fetch PC, in-flight tracking, buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= RESET_PC;
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      count_r       <= {LW{1'b0}};
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        fetch_pc_r    <= addr_s + WIDTH'(4);
        inflight_pc_r <= addr_s;
      end
      if (redirect_valid) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
      end
      count_r <= count_next_s;
    end
  end

  // Buffer storage: tag each returned word with the PC it was fetched from
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
    end
  end

  assign imem_en        = issue_s;
  assign imem_addr      = addr_s;
  assign out_valid      = valid_s;
  assign out_instr      = instr_mem_r[rd_ptr_r];
  assign out_pc         = pc_mem_r[rd_ptr_r];
  assign out_pred_taken = 1'b0;
  assign fifo_level     = count_r;

endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Bench for fetch_unit_buffered: directed vector table followed by randomized
// traffic, all checked against a queue-based model of the fetch stage.
module tb_fetch_unit_buffered;

  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic          clk;
  logic          rst;
  logic          imem_en;
  logic [W-1:0]  imem_addr;
  logic [W-1:0]  imem_rdata;
  logic          redirect_valid;
  logic [W-1:0]  redirect_target;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_instr;
  logic [W-1:0]  out_pc;
  logic          out_pred_taken;
  logic [2:0]    fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fetch_unit_buffered #(.WIDTH(W), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction contents as a function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // SRAM model: 1-cycle read latency, garbage when not enabled
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
    else         imem_rdata <= 32'hDEAD_BEEF;
  end

  // Reference model state
  logic [31:0] m_pc;
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] target;
    bit          ready;
    bit          e_en;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    int          e_level;
  } vec_t;

  // Apply one cycle of inputs, check outputs against the model (and optional
  // hand-written expectations), then advance the model across the clock edge.
  task automatic step(input bit r, input bit rd, input logic [31:0] tgt, input bit rdy,
                      input bit use_vec, input vec_t v);
    bit          e_en;
    logic [31:0] e_addr;
    bit          e_valid;
    @(negedge clk);
    rst = r; redirect_valid = rd; redirect_target = tgt; out_ready = rdy;
    #1;
    e_addr  = rd ? {tgt[31:2], 2'b00} : m_pc;
    e_en    = !r && (rd || (m_q.size() + int'(m_inf)) < DEPTH);
    e_valid = (m_q.size() > 0);
    chk("imem_en",   {31'd0, imem_en},   {31'd0, e_en});
    chk("imem_addr", imem_addr,          e_addr);
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    chk("fifo_level", {29'd0, fifo_level}, m_q.size());
    chk("pred_taken", {31'd0, out_pred_taken}, 32'd0);
    if (e_valid) begin
      chk("out_pc",    out_pc,    m_q[0]);
      chk("out_instr", out_instr, mem_word(m_q[0]));
    end
    if (use_vec) begin
      chk("vec_en",    {31'd0, imem_en},   {31'd0, v.e_en});
      chk("vec_addr",  imem_addr,          v.e_addr);
      chk("vec_valid", {31'd0, out_valid}, {31'd0, v.e_valid});
      chk("vec_level", {29'd0, fifo_level}, v.e_level);
      if (v.e_valid) chk("vec_pc", out_pc, v.e_pc);
    end
    // model update for the coming edge
    if (r) begin
      m_pc = RPC; m_inf = 0; m_inf_pc = RPC; m_q.delete();
    end else begin
      if (e_valid && rdy) void'(m_q.pop_front());
      if (rd) m_q.delete();
      else if (m_inf) m_q.push_back(m_inf_pc);
      if (e_en) begin
        m_pc = e_addr + 32'd4; m_inf = 1; m_inf_pc = e_addr;
      end else begin
        m_inf = 0;
      end
    end
    cyc++;
  endtask

  vec_t vecs[25];
  vec_t none;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0; out_ready = 1'b0;
    m_pc = RPC; m_inf = 0; m_inf_pc = RPC;
    none = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 0};
    //          rst  rdr  target         rdy  en   addr           vld  pc             lvl
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,        0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0,        0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100, 1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104, 1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_2003, 1'b1, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_0108, 1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_2004, 1'b0, 32'h0,        0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_2008, 1'b1, 32'h0000_2000, 1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_200C, 1'b1, 32'h0000_2004, 1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_2010, 1'b1, 32'h0000_2004, 2};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_2014, 1'b1, 32'h0000_2004, 3};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_2014, 1'b1, 32'h0000_2004, 4};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_2014, 1'b1, 32'h0000_2004, 4};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_2014, 1'b1, 32'h0000_2008, 3};
    vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_2018, 1'b1, 32'h0000_200C, 2};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,        0};
    vecs[16] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,        0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,        0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8, 1};
    vecs[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 1};
    vecs[20] = '{1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0000, 1};
    vecs[21] = '{1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0,        0};
    vecs[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0084, 1'b0, 32'h0,        0};
    vecs[23] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0088, 1'b1, 32'h0000_0080, 1};
    vecs[24] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_008C, 1'b1, 32'h0000_0084, 1};

    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, none);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, none);
    for (int i = 0; i < 25; i++) begin
      step(vecs[i].rst, vecs[i].redir, vecs[i].target, vecs[i].ready, 1'b1, vecs[i]);
    end

    // Stall until full, then reset with the buffer full
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, none);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("full_no_issue", {31'd0, imem_en}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, none);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, none);
    chk("after_rst_level", {29'd0, fifo_level}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          rd;
      bit          rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 299) == 0);
      rd  = ($urandom_range(0, 14) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (i % 500 > 480) rdy = 1'b0;
      tgt = $urandom();
      step(r, rd, tgt, rdy, 1'b0, none);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
